// File: rtl/dem_pkg.sv
// Shared definitions for the button-driven 4-bit counter: FSM state encoding,
// hex-to-7-segment patterns and the wrap-around step helpers.
package dem_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_RESET = 7'b1000000;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_dec(input logic [3:0] v, input logic [3:0] max);
    return (v == 4'd0 || v > max) ? max : v - 4'd1;
  endfunction

endpackage

// File: rtl/dem_4bit_btn_chia_xung.sv
// Prescaler for the auto-count mode: counts 0..DIV-1 while enabled and flags
// a single-cycle tick on the last count; clr forces it back to 0.
module chia_xung #(
  parameter int DIV = 50_000_000
) (
  input  logic ckht,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Compare uses only the registered count, so tick has no path from the buttons.
  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/dem_4bit_btn.sv
// Button-driven 4-bit wrap-around counter with MANUAL/AUTO/PAUSE modes.
// Optional registered 7-segment output enabled by defining DEM_SEG7_EN.
module dem_4bit_btn
  import dem_pkg::*;
#(
  parameter int MAX = 15,
  parameter int DIV = 50_000_000
) (
  input  logic       ckht,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_mode,
  output logic [3:0] q,
  output logic       auto_on,
  output logic       dir_dn
`ifdef DEM_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  localparam logic [3:0] MAX_Q = 4'(MAX);

  state_t     state_reg, state_next;
  logic [3:0] q_reg, q_next;
  logic       dir_reg, dir_next;
  logic       tick;
  logic       up_only, dn_only;

  chia_xung #(.DIV(DIV)) u_chia_xung (
    .ckht  (ckht),
    .rst_n (rst_n),
    .clr   (state_reg == MANUAL),
    .en    (state_reg == AUTO),
    .tick  (tick)
  );

  assign up_only = btn_up && !btn_dn;
  assign dn_only = btn_dn && !btn_up;

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= MANUAL;
      q_reg     <= 4'd0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      dir_reg   <= dir_next;
    end
  end

  // A mode pulse wins over everything else in its cycle: no step, no direction change.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    dir_next   = dir_reg;
    if (btn_mode) begin
      case (state_reg)
        MANUAL:  state_next = AUTO;
        AUTO:    state_next = PAUSE;
        default: state_next = MANUAL;
      endcase
    end else begin
      case (state_reg)
        MANUAL: begin
          if (up_only) q_next = wrap_inc(q_reg, MAX_Q);
          else if (dn_only) q_next = wrap_dec(q_reg, MAX_Q);
        end
        AUTO: begin
          if (tick) q_next = dir_reg ? wrap_dec(q_reg, MAX_Q) : wrap_inc(q_reg, MAX_Q);
          if (up_only) dir_next = 1'b0;
          else if (dn_only) dir_next = 1'b1;
        end
        PAUSE: ;
        default: state_next = MANUAL;
      endcase
    end
  end

  assign q       = q_reg;
  assign auto_on = (state_reg == AUTO);
  assign dir_dn  = dir_reg;

`ifdef DEM_SEG7_EN
  logic [6:0] seg_reg;

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) seg_reg <= SEG_RESET;
    else        seg_reg <= SEG_LUT[q_reg];
  end

  assign seg = seg_reg;
`endif

endmodule

// File: tb/tb_dem_4bit_btn.sv
// Self-checking bench for dem_4bit_btn: two instances (MAX=15 and MAX=9, DIV=4)
// driven in parallel and compared against an arithmetic reference model.
module tb_dem_4bit_btn;

  localparam int DIV = 4;

  logic       ckht = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_dn = 1'b0, btn_mode = 1'b0;
  logic [3:0] q0, q1;
  logic       auto0, auto1, dir0, dir1;
`ifdef DEM_SEG7_EN
  logic [6:0] seg0, seg1;
`endif

  always #5 ckht = ~ckht;

  dem_4bit_btn #(.MAX(15), .DIV(DIV)) u0 (
    .ckht(ckht), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
    .q(q0), .auto_on(auto0), .dir_dn(dir0)
`ifdef DEM_SEG7_EN
    , .seg(seg0)
`endif
  );

  dem_4bit_btn #(.MAX(9), .DIV(DIV)) u1 (
    .ckht(ckht), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
    .q(q1), .auto_on(auto1), .dir_dn(dir1)
`ifdef DEM_SEG7_EN
    , .seg(seg1)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=manual, 1=auto, 2=pause
  int m_mode, m_dir, m_phase;
  int m_q[2];
  int m_seg[2];
  int maxv[2] = '{15, 9};
  int seg_tb[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

  typedef struct {
    bit up; bit dn; bit md;
    int q0; int q1; bit aut; bit dir;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] got, input int want);
    checks++;
    if (got !== 32'(want)) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_dir = 0; m_phase = 0;
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0;
      m_seg[k] = 'h40;
    end
  endtask

  task automatic model_edge(input bit up, input bit dn, input bit md);
    bit tick;
    tick = (m_mode == 1) && (m_phase == DIV - 1);
    for (int k = 0; k < 2; k++) m_seg[k] = seg_tb[m_q[k]];
    if (md) begin
      m_mode = (m_mode + 1) % 3;
      m_phase = 0;
    end else if (m_mode == 0) begin
      for (int k = 0; k < 2; k++) begin
        if (up && !dn) m_q[k] = (m_q[k] + 1) % (maxv[k] + 1);
        else if (dn && !up) m_q[k] = (m_q[k] + maxv[k]) % (maxv[k] + 1);
      end
    end else if (m_mode == 1) begin
      if (tick)
        for (int k = 0; k < 2; k++)
          m_q[k] = m_dir ? (m_q[k] + maxv[k]) % (maxv[k] + 1) : (m_q[k] + 1) % (maxv[k] + 1);
      m_phase = (m_phase + 1) % DIV;
      if (up && !dn) m_dir = 0;
      else if (dn && !up) m_dir = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " q0"}, q0, m_q[0]);
    chk({tag, " q1"}, q1, m_q[1]);
    chk({tag, " auto0"}, auto0, (m_mode == 1) ? 1 : 0);
    chk({tag, " auto1"}, auto1, (m_mode == 1) ? 1 : 0);
    chk({tag, " dir0"}, dir0, m_dir);
    chk({tag, " dir1"}, dir1, m_dir);
`ifdef DEM_SEG7_EN
    chk({tag, " seg0"}, seg0, m_seg[0]);
    chk({tag, " seg1"}, seg1, m_seg[1]);
`endif
  endtask

  // Called just after a falling edge; drives one cycle and checks at the next falling edge.
  task automatic step(input bit up, input bit dn, input bit md, input string tag);
    btn_up = up; btn_dn = dn; btn_mode = md;
    @(posedge ckht);
    model_edge(up, dn, md);
    @(negedge ckht);
    btn_up = 1'b0; btn_dn = 1'b0; btn_mode = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    btn_up = 1'b0; btn_dn = 1'b0; btn_mode = 1'b0;
    @(negedge ckht);
    rst_n = 1'b0;
    model_reset();
    @(negedge ckht);
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // Wrap sequence: 17 ups then 2 downs
    for (int i = 0; i < 17; i++)
      vecs[i] = '{up: 1'b1, dn: 1'b0, md: 1'b0, q0: (i + 1) % 16, q1: (i + 1) % 10, aut: 1'b0, dir: 1'b0};
    vecs[17] = '{up: 1'b0, dn: 1'b1, md: 1'b0, q0: 0,  q1: 6, aut: 1'b0, dir: 1'b0};
    vecs[18] = '{up: 1'b0, dn: 1'b1, md: 1'b0, q0: 15, q1: 5, aut: 1'b0, dir: 1'b0};

    model_reset();
    do_reset();
    chk("reset q0 const", q0, 0);
    chk("reset auto const", auto0, 0);
`ifdef DEM_SEG7_EN
    chk("reset seg const", seg0, 'h40);
`endif

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].up, vecs[i].dn, vecs[i].md, "tbl");
      chk($sformatf("tbl[%0d] q0", i), q0, vecs[i].q0);
      chk($sformatf("tbl[%0d] q1", i), q1, vecs[i].q1);
      chk($sformatf("tbl[%0d] auto", i), auto0, vecs[i].aut);
      chk($sformatf("tbl[%0d] dir", i), dir0, vecs[i].dir);
    end

    // MAX=9 wrap boundary
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "max9 up");
    chk("max9 q1 at 9", q1, 9);
    step(1'b1, 1'b0, 1'b0, "max9 wrap");
    chk("max9 wrap up q1", q1, 0);
    chk("max9 wrap up q0", q0, 10);
    step(1'b0, 1'b1, 1'b0, "max9 back");
    chk("max9 wrap dn q1", q1, 9);

    // Auto mode timing, direction, collisions, pause
    do_reset();
    step(1'b0, 1'b0, 1'b1, "enter auto");
    chk("auto_on after mode", auto0, 1);
    idle(3, "auto wait");
    chk("auto no early step", q0, 0);
    idle(1, "auto step1");
    chk("auto first step", q0, 1);
    idle(4, "auto step2");
    chk("auto second step", q0, 2);
    idle(4, "auto step3");
    chk("auto third step", q0, 3);
    step(1'b0, 1'b1, 1'b0, "auto dn");
    chk("auto dir set", dir0, 1);
    idle(3, "auto down");
    chk("auto down step", q0, 2);
    step(1'b1, 1'b1, 1'b0, "auto both");
    chk("auto both keeps dir", dir0, 1);
    idle(2, "auto pre tick");
    step(1'b0, 1'b0, 1'b1, "mode on tick");
    chk("mode on tick no step", q0, 2);
    chk("mode on tick to pause", auto0, 0);
    for (int i = 0; i < 3 * DIV; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "pause");
    chk("pause frozen q0", q0, 2);
    chk("pause frozen dir", dir0, 1);
    step(1'b0, 1'b0, 1'b1, "to manual");
    step(1'b1, 1'b1, 1'b0, "manual both");
    chk("manual both q0", q0, 2);
    step(1'b1, 1'b0, 1'b0, "manual up");
    chk("manual after pause q0", q0, 3);

    // Asynchronous reset in the middle of auto counting
    step(1'b0, 1'b0, 1'b1, "auto again");
    idle(6, "auto run");
    @(posedge ckht);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst q0", q0, 0);
    chk("async rst q1", q1, 0);
    chk("async rst auto", auto0, 0);
    chk("async rst dir", dir0, 0);
    model_reset();
    @(negedge ckht);
    rst_n = 1'b1;
    check_all("after async rst");

`ifdef DEM_SEG7_EN
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, "seg walk");
      chk($sformatf("seg walk %0d", i), seg0, seg_tb[i]);
    end
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
